// File: rtl/mem_word_sequencer.sv
// Word-to-byte memory sequencer: 4 little-endian byte beats per 32-bit request; MEM_WORD_SEQ_ALIGN_CHECK_EN also rejects unaligned addresses.
// Latency: write rsp at cycle 5, read at 6, reject at 1; rsp_ready low stalls in RESP with req_ready low.
module mem_word_sequencer #(
    parameter int MEM_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  beat, beat_nxt;
    logic        wr_q, wr_nxt;
    logic [31:0] base_q, base_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [31:0] acc_q, acc_nxt;
    logic        ready_q, ready_nxt;
    logic        rsp_valid_nxt;
    logic [31:0] rsp_rdata_nxt;
    logic        rsp_err_nxt;
    logic        mem_wr_nxt;
    logic        mem_rd_nxt;
    logic [31:0] mem_addr_nxt;
    logic [7:0]  mem_wdata_nxt;

    // Beat selected for presentation on the memory port next cycle.
    logic        iss_en;
    logic        iss_wr;
    logic [31:0] iss_base;
    logic [31:0] iss_wdata;
    logic [1:0]  iss_idx;

    logic [1:0]  prev_idx;
    logic [32:0] last_byte;
    logic        out_of_range;
    logic        reject;

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign last_byte    = {1'b0, req_addr} + 33'd3;
    assign out_of_range = last_byte >= 33'(MEM_BYTES);

`ifdef MEM_WORD_SEQ_ALIGN_CHECK_EN
    assign reject = out_of_range | (req_addr[1:0] != 2'b00);
`else
    assign reject = out_of_range;
`endif

    assign prev_idx  = beat - 2'd1;
    assign req_ready = ready_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        wr_nxt        = wr_q;
        base_nxt      = base_q;
        wdata_nxt     = wdata_q;
        acc_nxt       = acc_q;
        ready_nxt     = 1'b0;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        iss_en        = 1'b0;
        iss_wr        = wr_q;
        iss_base      = base_q;
        iss_wdata     = wdata_q;
        iss_idx       = beat;

        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (req_valid) begin
                    ready_nxt = 1'b0;
                    wr_nxt    = req_wr;
                    base_nxt  = req_addr;
                    wdata_nxt = req_wdata;
                    beat_nxt  = 2'd0;
                    acc_nxt   = 32'd0;
                    if (reject) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = 32'd0;
                    end else begin
                        state_nxt = ISSUE;
                        iss_en    = 1'b1;
                        iss_wr    = req_wr;
                        iss_base  = req_addr;
                        iss_wdata = req_wdata;
                        iss_idx   = 2'd0;
                    end
                end
            end

            ISSUE: begin
                // Byte for the previous read beat arrives this cycle.
                if (!wr_q && beat != 2'd0) begin
                    acc_nxt[{prev_idx, 3'b000} +: 8] = mem_rdata;
                end
                if (beat == 2'd3) begin
                    if (wr_q) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b0;
                        rsp_rdata_nxt = 32'd0;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else begin
                    beat_nxt = beat + 2'd1;
                    iss_en   = 1'b1;
                    iss_idx  = beat + 2'd1;
                end
            end

            DRAIN: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b0;
                rsp_rdata_nxt = {mem_rdata, acc_q[23:0]};
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    ready_nxt     = 1'b1;
                    rsp_valid_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = 32'd0;
                end
            end

            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    always_comb begin
        mem_wr_nxt    = 1'b0;
        mem_rd_nxt    = 1'b0;
        mem_addr_nxt  = 32'd0;
        mem_wdata_nxt = 8'd0;
        if (iss_en) begin
            mem_wr_nxt   = iss_wr;
            mem_rd_nxt   = ~iss_wr;
            mem_addr_nxt = iss_base + {30'd0, iss_idx};
            if (iss_wr) begin
                mem_wdata_nxt = iss_wdata[{iss_idx, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= 2'd0;
            wr_q      <= 1'b0;
            base_q    <= 32'd0;
            wdata_q   <= 32'd0;
            acc_q     <= 32'd0;
            ready_q   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 8'd0;
        end else begin
            beat      <= beat_nxt;
            wr_q      <= wr_nxt;
            base_q    <= base_nxt;
            wdata_q   <= wdata_nxt;
            acc_q     <= acc_nxt;
            ready_q   <= ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_word_sequencer.sv
// Directed bench for mem_word_sequencer with a 16-byte behavioural memory.
module tb_mem_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:15];
    int          checks = 0;
    int          errors = 0;

    mem_word_sequencer #(.MEM_BYTES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr && mem_addr < 32'd16) mem[mem_addr[3:0]] <= mem_wdata;
        if (mem_rd && mem_addr < 32'd16) mem_rdata <= mem[mem_addr[3:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if ({rsp_valid, rsp_err, mem_wr, mem_rd} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_err, mem_wr, mem_rd}); end
        checks++; if ({rsp_rdata, mem_addr, mem_wdata} !== 72'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {rsp_rdata, mem_addr, mem_wdata}); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [31:0] wd;
        wd = 32'hA1B2C3D4;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd4; req_wdata = wd;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_c0_ready: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'(4 + i) || mem_wdata !== 8'(wd >> (8 * i)) || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_beat%0d: got wr=%b rd=%b addr=%h byte=%h rv=%b want wr=1 rd=0 addr=%h byte=%h rv=0", i, mem_wr, mem_rd, mem_addr, mem_wdata, rsp_valid, 4 + i, 8'(wd >> (8 * i)));
            end
            step();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 || mem_wr !== 1'b0) begin errors++; $display("FAIL wr_rsp_c5: got rv=%b err=%b rd=%h wr=%b want 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, mem_wr); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wr_after_rsp: got rv=%b ready=%b want 0 1", rsp_valid, req_ready); end

        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd4; req_wdata = 32'd0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'(4 + i) || mem_wdata !== 8'd0) begin
                errors++;
                $display("FAIL rd_beat%0d: got rd=%b wr=%b addr=%h byte=%h want rd=1 wr=0 addr=%h byte=00", i, mem_rd, mem_wr, mem_addr, mem_wdata, 4 + i);
            end
            step();
        end
        checks++; if (rsp_valid !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL rd_drain_c5: got rv=%b rd=%b want 0 0", rsp_valid, mem_rd); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hA1B2C3D4) begin errors++; $display("FAIL rd_rsp_c6: got rv=%b err=%b data=%h want 1 0 a1b2c3d4", rsp_valid, rsp_err, rsp_rdata); end
        step();
    endtask

    task automatic test_range();
        logic [31:0] bad [3];
        int          n;
        bad[0] = 32'd13; bad[1] = 32'hFFFFFFFE; bad[2] = 32'hFFFFFFFC;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd12;
        step();
        req_valid = 1'b0;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'd12 || rsp_err !== 1'b0) begin errors++; $display("FAIL range12_accept: got rd=%b addr=%h err=%b want 1 0000000c 0", mem_rd, mem_addr, rsp_err); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1F1E1D1C) begin errors++; $display("FAIL range12_rsp: got rv=%b err=%b data=%h want 1 0 1f1e1d1c", rsp_valid, rsp_err, rsp_rdata); end
        step();
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_wr = (k == 2); req_addr = bad[k]; req_wdata = 32'hDEADBEEF;
            step();
            req_valid = 1'b0;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 32'd0) begin
                errors++;
                $display("FAIL range_reject_%h: got rv=%b err=%b data=%h rd=%b wr=%b addr=%h want 1 1 0 0 0 0", bad[k], rsp_valid, rsp_err, rsp_rdata, mem_rd, mem_wr, mem_addr);
            end
            step();
        end
        checks++; if (mem[12] !== 8'h1C || mem[15] !== 8'h1F) begin errors++; $display("FAIL range_mem_untouched: got %h %h want 1c 1f", mem[12], mem[15]); end
    endtask

    task automatic test_backpressure();
        logic stall_bad;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd0; req_wdata = 32'h0BADF00D;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        stall_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd12;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || rsp_err !== 1'b0) stall_bad = 1'b1;
            step();
        end
        checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL bp_stall_hold: got bad=%b want 0", stall_bad); end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b want 1", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL bp_done: got rv=%b ready=%b rd=%b want 0 1 0", rsp_valid, req_ready, mem_rd); end
        checks++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h0BADF00D) begin errors++; $display("FAIL bp_mem: got %h want 0badf00d", {mem[3], mem[2], mem[1], mem[0]}); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd8; req_wdata = 32'h55667788;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if ({mem_wr, mem_rd, rsp_valid, rsp_err} !== 4'b0000 || {mem_addr, mem_wdata, rsp_rdata} !== 72'd0) begin errors++; $display("FAIL midrst_outputs: got wr=%b rd=%b rv=%b err=%b addr=%h byte=%h data=%h want all 0", mem_wr, mem_rd, rsp_valid, rsp_err, mem_addr, mem_wdata, rsp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
        checks++; if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h1B1A7788) begin errors++; $display("FAIL midrst_mem: got %h want 1b1a7788", {mem[11], mem[10], mem[9], mem[8]}); end
        step();
        checks++; if (mem_wr !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got wr=%b ready=%b want 0 1", mem_wr, req_ready); end
    endtask

    task automatic test_align();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd6;
        step();
        req_valid = 1'b0;
`ifdef MEM_WORD_SEQ_ALIGN_CHECK_EN
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_rd !== 1'b0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL align_reject: got rv=%b err=%b rd=%b data=%h want 1 1 0 0", rsp_valid, rsp_err, mem_rd, rsp_rdata); end
        step();
`else
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'(6 + i)) begin errors++; $display("FAIL align_beat%0d: got rd=%b addr=%h want 1 %h", i, mem_rd, mem_addr, 6 + i); end
            step();
        end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h7788A1B2) begin errors++; $display("FAIL align_data: got rv=%b err=%b data=%h want 1 0 7788a1b2", rsp_valid, rsp_err, rsp_rdata); end
        step();
`endif
    endtask

    task automatic load_req(input int k);
        req_valid = 1'b1;
        req_wr    = (k < 2);
        req_addr  = (k[0]) ? 32'd4 : 32'd0;
        req_wdata = (k == 0) ? 32'h11223344 : (k == 1) ? 32'h55667788 : 32'd0;
    endtask

    task automatic test_back_to_back();
        int          hs [4];
        logic [31:0] rd [4];
        int          n, r, cyc;
        n = 0; r = 0; cyc = 0;
        rsp_ready = 1'b1;
        load_req(0);
        while ((n < 4 || r < 4) && cyc < 100) begin
            if (req_ready === 1'b1 && n < 4) begin hs[n] = cyc; n++; end
            if (rsp_valid === 1'b1 && r < 4) begin rd[r] = rsp_rdata; r++; end
            step();
            cyc++;
            if (n < 4) load_req(n); else req_valid = 1'b0;
        end
        checks++; if (n !== 4 || r !== 4) begin errors++; $display("FAIL b2b_count: got hs=%0d rsp=%0d want 4 4", n, r); end
        if (n == 4) begin
            checks++; if (hs[1] - hs[0] !== 6 || hs[2] - hs[1] !== 6) begin errors++; $display("FAIL b2b_write_spacing: got %0d %0d want 6 6", hs[1] - hs[0], hs[2] - hs[1]); end
            checks++; if (hs[3] - hs[2] !== 7) begin errors++; $display("FAIL b2b_read_spacing: got %0d want 7", hs[3] - hs[2]); end
        end
        if (r == 4) begin
            checks++; if (rd[0] !== 32'd0 || rd[1] !== 32'd0 || rd[2] !== 32'h11223344 || rd[3] !== 32'h55667788) begin errors++; $display("FAIL b2b_data: got %h %h %h %h want 0 0 11223344 55667788", rd[0], rd[1], rd[2], rd[3]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        mem_rdata = 8'd0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1;
        rst = 1'b1;
        #1;
        test_reset();
        test_write_read();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_align();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_word_sequencer.md
# mem_word_sequencer

Word-to-byte access sequencer that sits directly upstream of the byte-wide data memory. It accepts 32-bit read/write requests over a valid/ready handshake and issues four consecutive byte accesses in little-endian order. Read bytes are reassembled into a 32-bit word, and out-of-range requests are rejected without touching memory. The block is the only master of the memory port.

## Interface
- `MEM_BYTES`, 16: memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_wr`  in  1: 1 = write, 0 = read.
- `req_addr`  in  32: byte address of the word's least significant byte.
- `req_wdata`  in  32: write data.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_rdata`  out  32: assembled read data; 0 for writes and errors.
- `rsp_err`  out  1: request rejected.
- `mem_wr`  out  1: byte write strobe.
- `mem_rd`  out  1: byte read strobe.
- `mem_addr`  out  32: byte address.
- `mem_wdata`  out  8: write byte.
- `mem_rdata`  in  8: read byte, valid the cycle after `mem_rd`.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch `req_wr`, `req_addr` and `req_wdata`, and clear the beat counter.
  - Range check uses a 33-bit sum, so there is no wrap: the request is out of range if `req_addr`+3 ≥ `MEM_BYTES`.
  - Out-of-range request → RESP with `rsp_err`=1 and no memory access.
  - Otherwise → ISSUE.
- **ISSUE**
  - Four beats, i = 0..3, one per cycle.
  - `mem_addr` = base+i.
  - Write: `mem_wr`=1 and `mem_wdata` = wdata[8i+7:8i].
  - Read: `mem_rd`=1.
  - After beat 3: a write goes to RESP, a read goes to DRAIN.
- **DRAIN** (read only)
  - Captures the byte returned for beat 3, then → RESP.
  - Read bytes are captured on the cycle after each `mem_rd`: byte i goes to `rsp_rdata`[8i+7:8i].
- **RESP**
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable.
  - When `rsp_ready`=1: → IDLE and `rsp_valid` drops next cycle.
- `mem_wr` and `mem_rd` are never both 1, and both are 0 outside ISSUE.
- `mem_addr` and `mem_wdata` read 0 when no strobe is active.

## Timing
- Reset values: `req_ready`=0 during `rst`, 1 the first cycle after; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_wr`=0, `mem_rd`=0, `mem_addr`=0, `mem_wdata`=0.
- All outputs are registered.
- Let cycle 0 be the cycle where `req_valid` and `req_ready` are both high.
  - Write: strobes in cycles 1–4; `rsp_valid` from cycle 5.
  - Read: strobes in cycles 1–4; bytes arrive in cycles 2–5; `rsp_valid` from cycle 6.
  - Error: `rsp_valid` from cycle 1.
- Back-to-back throughput:
  - Write: 6 cycles per request with `rsp_ready` held high.
  - Read: 7 cycles per request with `rsp_ready` held high.
  - `req_ready` returns in the cycle after the response handshake.
- `rsp_ready` low stalls in RESP indefinitely; nothing else changes.
- `req_valid` outside IDLE is ignored; `req_ready`=0 there.
- Reset mid-operation:
  - The next cycle shows all strobes 0 and the state is IDLE.
  - A partially written word stays partially written; no rollback.
- Boundary: `req_addr` = `MEM_BYTES`-4 is accepted; `MEM_BYTES`-3 is rejected; 0xFFFFFFFE is rejected (no wrap).

## Configuration
- Macro: `MEM_WORD_SEQ_ALIGN_CHECK_EN`.
- **Defined:** `req_addr`[1:0] ≠ 0 is rejected like an out-of-range request (`rsp_err`=1, no memory access, response in cycle 1).
- **Undefined:** unaligned addresses are accepted and sequenced byte by byte. Only the range check applies.

## Test plan
- **Aligned write then read.** Write `req_addr`=4, `req_wdata`=0xA1B2C3D4, then read addr 4.
  - Write issues `mem_addr` 4,5,6,7 with bytes D4,C3,B2,A1 in cycles 1–4; `rsp_valid` in cycle 5 with `rsp_err`=0.
  - Read returns `rsp_rdata`=0xA1B2C3D4 in cycle 6.
- **Range boundary** (`MEM_BYTES`=16).
  - Read addr 12: accepted.
  - Read addr 13: `rsp_err`=1 in cycle 1 with `rsp_rdata`=0 and no strobe.
  - Addr 0xFFFFFFFE: `rsp_err`=1.
- **Backpressure.** Write addr 0 with `rsp_ready`=0 for 5 cycles.
  - `rsp_valid` holds.
  - `req_ready`=0 and a second `req_valid` is ignored.
  - The response completes the cycle `rsp_ready`=1.
- **Reset mid-operation.** Assert `rst` during write beat 2 (cycle 2).
  - Next cycle: strobes 0, all outputs at reset values.
  - Memory holds bytes 0–1 new and bytes 2–3 old.
- **Alignment check.** Read addr 6.
  - With `MEM_WORD_SEQ_ALIGN_CHECK_EN`: `rsp_err`=1 and no strobes.
  - Without it: strobes at 6,7,8,9 and correct little-endian data.
- **Back-to-back.** Two writes then two reads with `req_valid` and `rsp_ready` held high: `req_ready` pulses every 6 cycles for the writes and every 7 cycles for the reads.
